// File: rtl/fetch_unit.sv
// Instruction fetch stage for iDEA: owns the PC, drives the synchronous instruction memory, and NOPs killed fetches.
// Optional halt-at-top-of-memory behaviour is enabled by defining IDEA_FETCH_WRAP_HALT_EN.
module fetch_unit #(
    parameter int IM_ADDR_WIDTH = 9,
    parameter int INST_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     stall_i,
    input  logic                     branch_taken_i,
    input  logic [IM_ADDR_WIDTH-1:0] branch_target_i,
    output logic [IM_ADDR_WIDTH-1:0] im_addr_o,
    output logic                     im_en_o,
    input  logic [INST_WIDTH-1:0]    im_data_i,
    output logic [INST_WIDTH-1:0]    inst_o,
    output logic                     inst_valid_o,
    output logic [IM_ADDR_WIDTH-1:0] pc_o,
    output logic                     halted_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef IDEA_FETCH_WRAP_HALT_EN
        FLUSH = 2'd2,
        HALT  = 2'd3
`else
        FLUSH = 2'd2
`endif
    } state_t;

    localparam logic [IM_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                   state_q, state_d;
    logic [IM_ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic                     im_en_q, im_en_d;
    logic                     valid_q, valid_d;
    logic [IM_ADDR_WIDTH-1:0] pc_q, pc_d;
`ifdef IDEA_FETCH_WRAP_HALT_EN
    logic                     halted_q, halted_d;
`endif

    always_comb begin
        state_d   = state_q;
        im_addr_d = im_addr_q;
        im_en_d   = im_en_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
`ifdef IDEA_FETCH_WRAP_HALT_EN
        halted_d  = halted_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = FLUSH;
                    im_addr_d = '0;
                    im_en_d   = 1'b1;
                end
            end
            RUN, FLUSH: begin
                if (branch_taken_i) begin
                    state_d   = FLUSH;
                    im_addr_d = branch_target_i;
                    im_en_d   = 1'b1;
                    valid_d   = 1'b0;
                end else if (!stall_i) begin
                    // The memory reads im_addr_q on this edge, so that word becomes the live one.
                    valid_d = 1'b1;
                    pc_d    = im_addr_q;
`ifdef IDEA_FETCH_WRAP_HALT_EN
                    if (im_addr_q == ADDR_MAX) begin
                        state_d = HALT;
                        im_en_d = 1'b0;
                    end else begin
                        state_d   = RUN;
                        im_addr_d = im_addr_q + IM_ADDR_WIDTH'(1);
                    end
`else
                    state_d   = RUN;
                    im_addr_d = im_addr_q + IM_ADDR_WIDTH'(1);
`endif
                end
            end
`ifdef IDEA_FETCH_WRAP_HALT_EN
            HALT: begin
                if (valid_q && !stall_i) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            im_addr_q <= '0;
            im_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
`ifdef IDEA_FETCH_WRAP_HALT_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            im_addr_q <= im_addr_d;
            im_en_q   <= im_en_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
`ifdef IDEA_FETCH_WRAP_HALT_EN
            halted_q  <= halted_d;
`endif
        end
    end

    // A stall must freeze the memory on the very edge it is sampled, or the held word would advance.
    assign im_en_o      = im_en_q && !(stall_i && !branch_taken_i);
    assign im_addr_o    = im_addr_q;
    assign inst_valid_o = valid_q;
    assign pc_o         = pc_q;
    assign inst_o       = valid_q ? im_data_i : '0;
`ifdef IDEA_FETCH_WRAP_HALT_EN
    assign halted_o     = halted_q;
`else
    assign halted_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level behavioural fetch model.
// Honours IDEA_FETCH_WRAP_HALT_EN the same way the design does.
module tb_fetch_unit;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
`ifdef IDEA_FETCH_WRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          stall_i;
    logic          branch_taken_i;
    logic [AW-1:0] branch_target_i;
    logic [AW-1:0] im_addr_o;
    logic          im_en_o;
    logic [DW-1:0] im_data_i;
    logic [DW-1:0] inst_o;
    logic          inst_valid_o;
    logic [AW-1:0] pc_o;
    logic          halted_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: mode 0 idle, 1 bubble, 2 running, 3 halted
    int m_mode;
    int m_next;
    int m_pc;
    bit m_valid;
    bit m_halted;

    logic [DW-1:0] mem [DEPTH];

    fetch_unit #(.IM_ADDR_WIDTH(AW), .INST_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .im_addr_o       (im_addr_o),
        .im_en_o         (im_en_o),
        .im_data_i       (im_data_i),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .pc_o            (pc_o),
        .halted_o        (halted_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory whose output holds while the enable is low.
    always @(posedge clk) begin
        if (im_en_o) im_data_i <= mem[im_addr_o];
    end

    task automatic model_reset();
        m_mode   = 0;
        m_next   = 0;
        m_pc     = 0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_edge(input bit start, input bit stall, input bit br, input int tgt);
        case (m_mode)
            0: if (start) begin
                m_mode = 1;
                m_next = 0;
            end
            3: if (m_valid && !stall) begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end
            default: begin
                if (br) begin
                    m_mode  = 1;
                    m_next  = tgt;
                    m_valid = 1'b0;
                end else if (!stall) begin
                    m_pc    = m_next;
                    m_valid = 1'b1;
                    if (HALT_EN && m_next == DEPTH - 1) m_mode = 3;
                    else begin
                        m_mode = 2;
                        m_next = (m_next + 1) % DEPTH;
                    end
                end
            end
        endcase
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] exp_inst;
        exp_inst = m_valid ? 32'(m_pc + 32'h100) : 32'h0;
        check_output({ctx, ".inst"},    inst_o,       exp_inst);
        check_output({ctx, ".valid"},   32'(inst_valid_o), 32'(m_valid));
        check_output({ctx, ".pc"},      32'(pc_o),    32'(m_pc));
        check_output({ctx, ".addr"},    32'(im_addr_o), 32'(m_next));
        check_output({ctx, ".halted"},  32'(halted_o), 32'(m_halted));
    endtask

    task automatic apply_stimulus(input string ctx, input bit start, input bit stall,
                                  input bit br, input int tgt);
        @(negedge clk);
        start_i         = start;
        stall_i         = stall;
        branch_taken_i  = br;
        branch_target_i = AW'(tgt);
        @(posedge clk);
        model_edge(start, stall, br, tgt);
        #1;
        check_all(ctx);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
        model_reset();
        #1;
        check_all("reset");
        check_output("reset.im_en", 32'(im_en_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit reached;
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k) + 32'h100;
        rst = 1'b1;
        start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        check_output("por.im_en", 32'(im_en_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // No fetch until start
        apply_stimulus("idle", 0, 0, 0, 0);
        apply_stimulus("idle_br", 0, 0, 1, 33);

        // Start, bubble, then 0x100, 0x101, 0x102
        apply_stimulus("start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus("seq", 0, 0, 0, 0);
        check_output("seq.word2", inst_o, 32'h102);

        // Advance to pc 5, then stall three cycles
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_valid && m_pc == 5) reached = 1'b1;
            else apply_stimulus("to_pc5", 0, 0, 0, 0);
        end
        check_output("reach_pc5", 32'(reached), 32'h1);
        for (int i = 0; i < 3; i++) apply_stimulus("stall", 0, 1, 0, 0);
        check_output("stall.hold", inst_o, 32'h105);
        apply_stimulus("unstall", 0, 0, 0, 0);
        check_output("unstall.word", inst_o, 32'h106);

        // Branch to 0x40 from RUN
        apply_stimulus("branch", 0, 0, 1, 'h40);
        apply_stimulus("br_tgt", 0, 0, 0, 0);
        check_output("br_tgt.word", inst_o, 32'h140);
        apply_stimulus("br_next", 0, 0, 0, 0);

        // Branch wins over stall, then re-redirect during FLUSH, with a stall inside FLUSH
        apply_stimulus("br_stall", 0, 1, 1, 'h80);
        apply_stimulus("flush_stall", 0, 1, 0, 0);
        apply_stimulus("flush_br", 0, 0, 1, 'h10);
        apply_stimulus("rebr_tgt", 0, 0, 0, 0);
        check_output("rebr_tgt.word", inst_o, 32'h110);
        apply_stimulus("start_in_run", 1, 0, 0, 0);

        // Asynchronous reset between edges while running
        @(negedge clk);
        #2;
        rst = 1'b1;
        start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check_output("async_rst.im_en", 32'(im_en_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus("post_rst", 0, 0, 0, 0);
        check_output("post_rst.im_en", 32'(im_en_o), 32'h0);

        // Randomized traffic
        apply_stimulus("rnd_start", 1, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            apply_stimulus("rnd",
                           $urandom_range(0, 15) == 0,
                           $urandom_range(0, 3) == 0,
                           $urandom_range(0, 9) == 0,
                           int'($urandom_range(0, DEPTH - 1)));
        end

        // Top-of-memory boundary
        pulse_reset();
        apply_stimulus("wrap_start", 1, 0, 0, 0);
        apply_stimulus("wrap_br", 0, 0, 1, 'h1FE);
        for (int i = 0; i < 5; i++) apply_stimulus("wrap", 0, 0, 0, 0);
        apply_stimulus("wrap_start_again", 1, 0, 0, 0);
        apply_stimulus("wrap_branch_again", 0, 0, 1, 'h20);
        apply_stimulus("wrap_tail", 0, 0, 0, 0);
        check_output("wrap.halted_final", 32'(halted_o), HALT_EN ? 32'h1 : 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
